conv_mac_engine: RTL and testbench

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/conv_mac_pkg.sv | 22 ++
 rtl/conv_mac_lane_sum.sv | 35 +++
 rtl/conv_mac_engine.sv | 139 +++++++++++++
 tb/tb_conv_mac_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// Shared types and width helpers for the convolution MAC engine.
package conv_mac_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_K      = 5;
    localparam int DEF_LANES  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic int iw_f(input int k);
        return $clog2(k * k + 1);
    endfunction

    function automatic int acc_w_f(input int dw, input int k);
        return 2 * dw + $clog2(k * k + 1);
    endfunction

endpackage

// File: rtl/conv_mac_lane_sum.sv
// LANES signed multipliers feeding one summation, purely combinational.
module conv_mac_lane_sum
    import conv_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int ACC_W  = acc_w_f(DEF_DATA_W, DEF_K)
) (
    input  logic [LANES*DATA_W-1:0] win_i,
    input  logic [LANES*DATA_W-1:0] wgt_i,
    output logic [ACC_W-1:0]        sum_o
);
    localparam int PW = 2 * DATA_W;

    // Operands are sign-extended to PW bits, so the low PW bits of the
    // product are the exact signed product.
    always_comb begin
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [PW-1:0] p;
        a     = '0;
        b     = '0;
        p     = '0;
        sum_o = '0;
        for (int l = 0; l < LANES; l++) begin
            a = {{DATA_W{win_i[l*DATA_W+DATA_W-1]}},
                 win_i[l*DATA_W +: DATA_W]};
            b = {{DATA_W{wgt_i[l*DATA_W+DATA_W-1]}},
                 wgt_i[l*DATA_W +: DATA_W]};
            p = a * b;
            sum_o = sum_o + {{(ACC_W-PW){p[PW-1]}}, p};
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// KxK window/weight convolution MAC, LANES products per cycle.
// Define CONV_MAC_RELU_EN to clamp negative results to zero.
module conv_mac_engine
    import conv_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int K      = DEF_K,
    parameter int LANES  = DEF_LANES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [iw_f(K)-1:0]            data_idx,
    input  logic                          data_wr,
    input  logic                          shift,
    input  logic [DATA_W-1:0]             weight_in,
    input  logic [iw_f(K)-1:0]            weight_idx,
    input  logic                          weight_wr,
    input  logic                          start,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [acc_w_f(DATA_W,K)-1:0]  answer
);
    localparam int KK    = K * K;
    localparam int N     = KK / LANES;
    localparam int IW    = iw_f(K);
    localparam int ACC_W = acc_w_f(DATA_W, K);
    localparam int CW    = (N > 1) ? $clog2(N) : 1;

    if (KK % LANES != 0) begin : g_bad_lanes
        $error("K*K must be divisible by LANES");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] win_q [KK];
    logic [DATA_W-1:0] win_d [KK];
    logic [DATA_W-1:0] wgt_q [KK+1];
    logic [DATA_W-1:0] wgt_d [KK+1];

    logic [LANES*DATA_W-1:0] lane_win, lane_wgt;
    logic [ACC_W-1:0]        lane_sum;

    always_comb begin
        logic [IW-1:0] sel;
        sel      = '0;
        lane_win = '0;
        lane_wgt = '0;
        for (int l = 0; l < LANES; l++) begin
            sel = IW'(int'(cnt_q) * LANES + l);
            lane_win[l*DATA_W +: DATA_W] = win_q[sel];
            lane_wgt[l*DATA_W +: DATA_W] = wgt_q[sel];
        end
    end

    conv_mac_lane_sum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_lane_sum (
        .win_i  (lane_win),
        .wgt_i  (lane_wgt),
        .sum_o  (lane_sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        win_d   = win_q;
        wgt_d   = wgt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    cnt_d   = '0;
                    acc_d   = {{(ACC_W-DATA_W){wgt_q[KK][DATA_W-1]}},
                               wgt_q[KK]};
                end else begin
                    // Shift first so a same-index write overrides it.
                    if (shift) begin
                        for (int r = 0; r < K; r++) begin
                            for (int c = 0; c < K - 1; c++) begin
                                win_d[IW'(r*K+c)] = win_q[IW'(r*K+c+1)];
                            end
                        end
                    end
                    if (data_wr && data_idx < IW'(KK)) begin
                        win_d[data_idx] = data_in;
                    end
                    if (weight_wr && weight_idx <= IW'(KK)) begin
                        wgt_d[weight_idx] = weight_in;
                    end
                end
            end
            ACC: begin
                acc_d = acc_q + lane_sum;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < KK; i++) win_q[i] <= '0;
            for (int i = 0; i <= KK; i++) wgt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            win_q   <= win_d;
            wgt_q   <= wgt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);

`ifdef CONV_MAC_RELU_EN
    assign answer = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    assign answer = acc_q;
`endif

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine at default parameters.
module tb_conv_mac_engine;
    localparam int DW    = 32;
    localparam int IW    = 5;
    localparam int ACC_W = 69;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] weight_in = '0;
    logic [IW-1:0] data_idx = '0;
    logic [IW-1:0] weight_idx = '0;
    logic data_wr = 1'b0;
    logic shift = 1'b0;
    logic weight_wr = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic busy, out_valid;
    logic signed [ACC_W-1:0] answer;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_mac_engine dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_idx   (data_idx),
        .data_wr    (data_wr),
        .shift      (shift),
        .weight_in  (weight_in),
        .weight_idx (weight_idx),
        .weight_wr  (weight_wr),
        .start      (start),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .answer     (answer)
    );

    task automatic check(input string tag,
                         input logic signed [ACC_W-1:0] got,
                         input logic signed [ACC_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wdata(input int idx, input logic [DW-1:0] v);
        data_idx = IW'(idx);
        data_in  = v;
        data_wr  = 1'b1;
        @(negedge clk);
        data_wr  = 1'b0;
    endtask

    task automatic wweight(input int idx, input logic [DW-1:0] v);
        weight_idx = IW'(idx);
        weight_in  = v;
        weight_wr  = 1'b1;
        @(negedge clk);
        weight_wr  = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int lat0);
        int lat;
        lat = lat0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, ACC_W'(lat), ACC_W'(5));
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_done_v"}, ACC_W'(out_valid), ACC_W'(0));
        check({tag, "_done_busy"}, ACC_W'(busy), ACC_W'(0));
    endtask

    task automatic run(input string tag,
                       input logic signed [ACC_W-1:0] exp,
                       input int hold);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_wr = 1'b0;
        check({tag, "_busy"}, ACC_W'(busy), ACC_W'(1));
        wait_valid(tag, 0);
        check({tag, "_ans"}, answer, exp);
        for (int h = 0; h < hold; h++) begin
            data_idx = '0;
            data_in  = 32'd100;
            data_wr  = 1'b1;
            @(negedge clk);
            data_wr  = 1'b0;
            check({tag, "_hold_v"}, ACC_W'(out_valid), ACC_W'(1));
            check({tag, "_hold_ans"}, answer, exp);
        end
        pop(tag);
    endtask

    task automatic stray(input string tag);
        int n;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check(tag, ACC_W'(n), ACC_W'(0));
    endtask

    initial begin
        logic signed [ACC_W-1:0] big;
        int e;

        repeat (3) @(negedge clk);
        check("rst_busy", ACC_W'(busy), ACC_W'(0));
        check("rst_valid", ACC_W'(out_valid), ACC_W'(0));
        check("rst_answer", answer, ACC_W'(0));
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 25; i++) wweight(i, 32'd1);
        wweight(25, 32'd0);
        for (int i = 0; i < 25; i++) wdata(i, DW'(i + 1));
        run("sum325", ACC_W'(325), 3);

        // Out-of-range writes and a write coinciding with start are dropped
        wdata(25, 32'd1000);
        wdata(31, 32'd1000);
        wweight(31, 32'd7);
        data_idx = '0;
        data_in  = 32'd100;
        data_wr  = 1'b1;
        run("startwr", ACC_W'(325), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("midstart", 2);
        check("midstart_ans", answer, ACC_W'(325));
        pop("midstart");
        stray("midstart_stray");

        for (int i = 0; i < 25; i++) wdata(i, -32'sd2);
        wweight(25, 32'd10);
`ifdef CONV_MAC_RELU_EN
        run("neg", ACC_W'(0), 0);
`else
        run("neg", ACC_W'(-40), 0);
`endif

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", ACC_W'(busy), ACC_W'(0));
        check("abort_valid", ACC_W'(out_valid), ACC_W'(0));
        check("abort_answer", answer, ACC_W'(0));
        reset = 1'b1;
        stray("abort_stray");

        for (int i = 0; i < 25; i++) wweight(i, 32'h8000_0000);
        for (int i = 0; i < 25; i++) wdata(i, 32'h8000_0000);
        big = ACC_W'(25);
        big = big << 62;
        run("extreme", big, 0);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) wdata(r * 5 + c, DW'(c));
        shift    = 1'b1;
        data_idx = IW'(4);
        data_in  = 32'd9;
        data_wr  = 1'b1;
        @(negedge clk);
        shift    = 1'b0;
        data_wr  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == 4) e = 9;
            else if (i % 5 == 4) e = 4;
            else e = i % 5 + 1;
            wweight(i, 32'd1);
            run($sformatf("win%0d", i), ACC_W'(e), 0);
            wweight(i, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
